// File: rtl/sc_nn_pkg.sv
// sc_nn_pkg: shared state type, width helpers and default sizes for the sc_nn run controller
package sc_nn_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARMUP, S_RUN, S_ARGMAX, S_DONE} sc_seq_state_t;
  localparam int DEF_N2 = 10;
  localparam int DEF_STREAM_LEN = 256;
  localparam int DEF_WARMUP = 8;
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sc_seq_argmax.sv
// sc_seq_argmax: one-entry-per-cycle argmax scan over a packed count vector, lowest index wins ties
module sc_seq_argmax #(
  parameter int N = 10,
  parameter int W = 9,
  parameter int IW = 4
)(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           go,
  input  logic [N*W-1:0] count,
  output logic           valid,
  output logic [IW-1:0]  idx,
  output logic [W-1:0]   score
);
  logic          active, take;
  logic [IW-1:0] p, bidx, nidx;
  logic [W-1:0]  best, cur, nbest;
  // entry 0 seeds the running best; later entries replace it only when strictly larger
  always_comb begin
    cur = count[int'(p)*W +: W];
    take = p == '0 || cur > best;
    nbest = take ? cur : best;
    nidx = take ? p : bidx;
  end
  // scan pointer and running best; result registers are loaded with the final step's outcome
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      active <= 1'b0;
      p <= '0;
      bidx <= '0;
      best <= '0;
      valid <= 1'b0;
      idx <= '0;
      score <= '0;
    end else if (go) begin
      active <= 1'b1;
      p <= '0;
      valid <= 1'b0;
    end else if (active) begin
      best <= nbest;
      bidx <= nidx;
      p <= p + 1'b1;
      active <= p != IW'(N - 1);
      valid <= p == IW'(N - 1);
      if (p == IW'(N - 1)) begin
        idx <= nidx;
        score <= nbest;
      end
    end else
      valid <= 1'b0;
endmodule

// File: rtl/sc_nn_sequencer.sv
// sc_nn_sequencer: runs one stochastic-computing inference (clear, warm-up, measure, argmax) behind a start/done handshake
module sc_nn_sequencer
  import sc_nn_pkg::*;
#(
  parameter int N2 = DEF_N2,
  parameter int STREAM_LEN = DEF_STREAM_LEN,
  parameter int WARMUP = DEF_WARMUP,
  localparam int CNT_W = cnt_w(STREAM_LEN),
  localparam int IDX_W = idx_w(N2)
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N2-1:0]      nn_dout,
  output logic               nn_clear,
  output logic               stream_en,
  output logic               busy,
  output logic               done,
  output logic               class_valid,
  output logic [IDX_W-1:0]   class_idx,
  output logic [CNT_W-1:0]   class_score,
  output logic [N2*CNT_W-1:0] class_count
);
  localparam int PH_MAX = N2 > STREAM_LEN ? (N2 > WARMUP ? N2 : WARMUP) : (STREAM_LEN > WARMUP ? STREAM_LEN : WARMUP);
  localparam int PH_W = cnt_w(PH_MAX);
  sc_seq_state_t state, nxt;
  logic [PH_W-1:0] ph;
  logic [CNT_W-1:0] cnt [N2];
  logic accept, kill, go, scan_valid, nn_clear_d, stream_en_d, class_valid_d;
  assign accept = state == S_IDLE && start;
  assign kill = state != S_IDLE && abort;
  assign busy = state != S_IDLE;
  assign go = state == S_RUN && nxt == S_ARGMAX;
  assign done = scan_valid && state == S_DONE;
  // state register plus a phase counter that restarts on every state change
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      ph <= '0;
    end else begin
      state <= nxt;
      ph <= nxt != state ? '0 : ph + 1'b1;
    end
  // next state; abort overrides everything outside IDLE
  always_comb
    nxt = kill ? S_IDLE :
          state == S_IDLE ? (start ? S_CLEAR : S_IDLE) :
          state == S_CLEAR ? (WARMUP == 0 ? S_RUN : S_WARMUP) :
          state == S_WARMUP ? (int'(ph) == WARMUP - 1 ? S_RUN : S_WARMUP) :
          state == S_RUN ? (int'(ph) == STREAM_LEN - 1 ? S_ARGMAX : S_RUN) :
          state == S_ARGMAX ? (int'(ph) == N2 - 1 ? S_DONE : S_ARGMAX) : S_IDLE;
  // output values for the coming cycle, decoded from the next state
  always_comb begin
    nn_clear_d = nxt == S_CLEAR;
    stream_en_d = nxt == S_WARMUP || nxt == S_RUN;
    class_valid_d = nxt == S_DONE ? 1'b1 : (accept || kill) ? 1'b0 : class_valid;
  end
  // registered control outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      nn_clear <= 1'b0;
      stream_en <= 1'b0;
      class_valid <= 1'b0;
    end else begin
      nn_clear <= nn_clear_d;
      stream_en <= stream_en_d;
      class_valid <= class_valid_d;
    end
  for (genvar j = 0; j < N2; j++) begin : g_cnt
    // per-class ones counter, cleared on an accepted start and counting only during measurement
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt[j] <= '0;
      else if (accept) cnt[j] <= '0;
      else if (state == S_RUN) cnt[j] <= cnt[j] + CNT_W'(nn_dout[j]);
    assign class_count[j*CNT_W +: CNT_W] = cnt[j];
  end
  sc_seq_argmax #(.N(N2), .W(CNT_W), .IW(IDX_W)) u_argmax (
    .clk(clk),
    .reset_n(reset_n),
    .go(go),
    .count(class_count),
    .valid(scan_valid),
    .idx(class_idx),
    .score(class_score)
  );
endmodule

// File: tb/tb_sc_nn_sequencer.sv
// tb_sc_nn_sequencer: randomized self-checking bench for sc_nn_sequencer against a timeline/count model
module tb_sc_nn_sequencer;
  localparam int N2 = 10, S = 256, W = 8, CW = 9, IW = 4;
  localparam int L = 2 + W + S + N2;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [N2-1:0] nn_dout = '0;
  logic nn_clear, stream_en, busy, done, class_valid;
  logic [IW-1:0] class_idx;
  logic [CW-1:0] class_score;
  logic [N2*CW-1:0] class_count;
  int checks = 0, errors = 0;
  int exp_cnt [N2];
  int thr [N2];
  int exp_idx = 0, exp_score = 0;
  bit exp_valid = 1'b0;

  sc_nn_sequencer #(.N2(N2), .STREAM_LEN(S), .WARMUP(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .nn_dout(nn_dout),
    .nn_clear(nn_clear), .stream_en(stream_en), .busy(busy), .done(done),
    .class_valid(class_valid), .class_idx(class_idx), .class_score(class_score),
    .class_count(class_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N2*CW-1:0] flat_cnt();
    logic [N2*CW-1:0] f;
    for (int j = 0; j < N2; j++) f[j*CW +: CW] = CW'(exp_cnt[j]);
    return f;
  endfunction

  function automatic logic [N2-1:0] stim(input int mode, input int k);
    logic [N2-1:0] v;
    int r;
    bit run, warm;
    r = k - (2 + W);
    run = r >= 0 && r < S;
    warm = k >= 2 && k < 2 + W;
    v = N2'($urandom);
    if (mode == 0 && run) v = 10'b0000001000;
    if (mode == 1) v = warm ? '1 : '0;
    if (mode == 2 && run) begin
      v = '0;
      v[2] = r < 100;
      v[7] = r >= 100 && r < 200;
      v[5] = r < 99;
    end
    if (mode == 3 && run)
      for (int j = 0; j < N2; j++) v[j] = $urandom_range(0, 99) < thr[j];
    return v;
  endfunction

  task automatic expect_argmax();
    exp_idx = 0;
    exp_score = exp_cnt[0];
    for (int j = 1; j < N2; j++)
      if (exp_cnt[j] > exp_score) begin
        exp_score = exp_cnt[j];
        exp_idx = j;
      end
    exp_valid = 1'b1;
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_valid"}, class_valid, exp_valid);
    chk({tag, "_idx"}, class_idx, exp_idx);
    chk({tag, "_score"}, class_score, exp_score);
    chk({tag, "_counts"}, class_count, flat_cnt());
  endtask

  task automatic do_run(input int mode, input int restart_r, input int abort_r,
                        input bit abort_with_start, input bit start_in_done, input int rst_a);
    bit aborted;
    bit run;
    int r;
    logic [N2-1:0] v;
    aborted = 1'b0;
    for (int j = 0; j < N2; j++) begin
      thr[j] = $urandom_range(0, 100);
      exp_cnt[j] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    abort = abort_with_start;
    nn_dout = N2'($urandom);
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      r = k - (2 + W);
      run = r >= 0 && r < S;
      if (aborted)
        chk("ctl_aborted", {nn_clear, stream_en, busy, done, class_valid}, 5'b0);
      else
        chk("ctl", {nn_clear, stream_en, busy, done, class_valid},
            {k == 1, k >= 2 && k < 2 + W + S, k <= L, k == L, k >= L});
      if (k == L && !aborted) begin
        expect_argmax();
        chk_result("result");
      end
      if (rst_a >= 0 && k == 2 + W + S + rst_a) begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async", {nn_clear, stream_en, busy, done, class_valid, class_idx, class_score, class_count}, '0);
        start = 1'b0;
        abort = 1'b0;
        nn_dout = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < N2; j++) exp_cnt[j] = 0;
        exp_valid = 1'b0;
        exp_idx = 0;
        exp_score = 0;
        chk("rst_idle", {nn_clear, stream_en, busy, done}, 4'b0);
        chk_result("rst");
        return;
      end
      v = stim(mode, k);
      if (run && !aborted)
        for (int j = 0; j < N2; j++) exp_cnt[j] += int'(v[j]);
      nn_dout = v;
      start = (run && r == restart_r) || (start_in_done && k == L);
      abort = run && r == abort_r;
      if (abort) begin
        aborted = 1'b1;
        exp_valid = 1'b0;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_state", {nn_clear, stream_en, busy, done, class_valid, class_idx, class_score, class_count}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_idle", {nn_clear, stream_en, busy, done, class_valid}, 5'b0);
    do_run(0, -1, -1, 1'b0, 1'b0, -1);
    do_run(1, -1, -1, 1'b0, 1'b0, -1);
    do_run(2, -1, -1, 1'b0, 1'b0, -1);
    do_run(3, 50, -1, 1'b0, 1'b1, -1);
    do_run(3, -1, -1, 1'b0, 1'b0, -1);
    do_run(3, -1, 10, 1'b0, 1'b0, -1);
    do_run(3, -1, -1, 1'b1, 1'b0, -1);
    do_run(3, -1, -1, 1'b0, 1'b0, 4);
    do_run(0, -1, -1, 1'b0, 1'b0, -1);
    do_run(3, -1, -1, 1'b0, 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
